// File: rtl/sprite_pkg.sv
// Shared constants, FSM state encoding and sprite IDs for the enemy sprite blitter.
// The walking frames are ordered as direction x step.
package sprite_pkg;

   localparam int SPRITE_W = 16;
   localparam int SPRITE_H = 16;
   localparam int X_MAX    = 320;
   localparam int Y_MAX    = 240;

   localparam logic [5:0] TRANSPARENT = 6'b000000;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } blit_state_e;

   // ID = {direction[1:0], step}
   localparam logic [2:0] SPR_WALK_UP_0    = 3'd0;
   localparam logic [2:0] SPR_WALK_UP_1    = 3'd1;
   localparam logic [2:0] SPR_WALK_DOWN_0  = 3'd2;
   localparam logic [2:0] SPR_WALK_DOWN_1  = 3'd3;
   localparam logic [2:0] SPR_WALK_LEFT_0  = 3'd4;
   localparam logic [2:0] SPR_WALK_LEFT_1  = 3'd5;
   localparam logic [2:0] SPR_WALK_RIGHT_0 = 3'd6;
   localparam logic [2:0] SPR_WALK_RIGHT_1 = 3'd7;

endpackage

// File: rtl/sprite_blitter_if.sv
// Request, ROM and pixel-stream signals of one sprite blitter.
// The mirror request line exists only when SPRITE_MIRROR_EN is defined.
interface sprite_blitter_if #(
   parameter int ID_W   = 3,
   parameter int ADDR_W = 11
);

   logic              start;
   logic [ID_W-1:0]   sprite_id;
   logic [8:0]        x_pos;
   logic [7:0]        y_pos;
`ifdef SPRITE_MIRROR_EN
   logic              mirror;
`endif
   logic [ADDR_W-1:0] rom_address;
   logic [5:0]        rom_q;
   logic [8:0]        x_draw;
   logic [7:0]        y_draw;
   logic [5:0]        colour;
   logic              VGA_write;
   logic              busy;
   logic              draw_done;

`ifdef SPRITE_MIRROR_EN
   modport master (
      output start, sprite_id, x_pos, y_pos, mirror, rom_q,
      input  rom_address, x_draw, y_draw, colour, VGA_write, busy, draw_done
   );

   modport slave (
      input  start, sprite_id, x_pos, y_pos, mirror, rom_q,
      output rom_address, x_draw, y_draw, colour, VGA_write, busy, draw_done
   );
`else
   modport master (
      output start, sprite_id, x_pos, y_pos, rom_q,
      input  rom_address, x_draw, y_draw, colour, VGA_write, busy, draw_done
   );

   modport slave (
      input  start, sprite_id, x_pos, y_pos, rom_q,
      output rom_address, x_draw, y_draw, colour, VGA_write, busy, draw_done
   );
`endif

endinterface

// File: rtl/sprite_addr_gen.sv
// Column/row walker for one sprite and the ROM address it implies.
// With SPRITE_MIRROR_EN the column index is reversed when the mirror latch is set.
module sprite_addr_gen #(
   parameter int SPRITE_W = 16,
   parameter int SPRITE_H = 16,
   parameter int ID_W     = 3,
   parameter int ADDR_W   = 11
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         advance,
   input  logic [ID_W-1:0]              id,
`ifdef SPRITE_MIRROR_EN
   input  logic                         mirror,
`endif
   output logic [$clog2(SPRITE_W)-1:0]  col,
   output logic [$clog2(SPRITE_H)-1:0]  row,
   output logic                         last,
   output logic [ADDR_W-1:0]            rom_address
);

   import sprite_pkg::*;

   localparam int CW = $clog2(SPRITE_W);
   localparam int RW = $clog2(SPRITE_H);

   localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

   logic [CW-1:0] col_eff;

   // Both counters wrap naturally, so they are back at zero after the last pixel.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (advance) begin
         col <= col + CW'(1);
         if (col == COL_LAST) begin
            row <= row + RW'(1);
         end
      end
   end

`ifdef SPRITE_MIRROR_EN
   // SPRITE_W is a power of two, so SPRITE_W-1-col is a bitwise inversion.
   assign col_eff = mirror ? ~col : col;
`else
   assign col_eff = col;
`endif

   assign last        = (col == COL_LAST) && (row == ROW_LAST);
   assign rom_address = {id, row, col_eff};

endmodule

// File: rtl/sprite_blitter.sv
// Walks one 16x16 sprite from the enemy ROM and emits a clipped, transparency-masked pixel stream.
// SPRITE_MIRROR_EN adds a latched horizontal-flip request.
module sprite_blitter #(
   parameter int          SPRITE_W    = sprite_pkg::SPRITE_W,
   parameter int          SPRITE_H    = sprite_pkg::SPRITE_H,
   parameter int          ID_W        = 3,
   parameter int          ADDR_W      = 11,
   parameter int          X_MAX       = sprite_pkg::X_MAX,
   parameter int          Y_MAX       = sprite_pkg::Y_MAX,
   parameter logic [5:0]  TRANSPARENT = sprite_pkg::TRANSPARENT
) (
   input  logic              clock,
   input  logic              reset,
   sprite_blitter_if.slave   bus
);

   import sprite_pkg::*;

   localparam int CW = $clog2(SPRITE_W);
   localparam int RW = $clog2(SPRITE_H);

   blit_state_e state;
   blit_state_e next_state;

   logic              accept;
   logic              advance;
   logic              busy_c;
   logic              done_c;

   logic [ID_W-1:0]   id_lat;
   logic [8:0]        x_lat;
   logic [7:0]        y_lat;
`ifdef SPRITE_MIRROR_EN
   logic              mirror_lat;
`endif

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              last;
   logic [ADDR_W-1:0] rom_address;

   logic [9:0]        x_sum;
   logic [8:0]        y_sum;
   logic              pipe_valid;
   logic              pipe_clip;
   logic [8:0]        x_draw_r;
   logic [7:0]        y_draw_r;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A start arriving outside IDLE is simply dropped; nothing is queued.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      advance    = 1'b0;
      busy_c     = 1'b1;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (bus.start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            advance = 1'b1;
            if (last) begin
               next_state = FLUSH;
            end
         end
         FLUSH: begin
            next_state = DONE;
         end
         DONE: begin
            done_c     = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         id_lat <= '0;
         x_lat  <= '0;
         y_lat  <= '0;
`ifdef SPRITE_MIRROR_EN
         mirror_lat <= 1'b0;
`endif
      end else if (accept) begin
         id_lat <= bus.sprite_id;
         x_lat  <= bus.x_pos;
         y_lat  <= bus.y_pos;
`ifdef SPRITE_MIRROR_EN
         mirror_lat <= bus.mirror;
`endif
      end
   end

   sprite_addr_gen #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .ID_W     (ID_W),
      .ADDR_W   (ADDR_W)
   ) u_addr_gen (
      .clock       (clock),
      .reset       (reset),
      .clear       (accept),
      .advance     (advance),
      .id          (id_lat),
`ifdef SPRITE_MIRROR_EN
      .mirror      (mirror_lat),
`endif
      .col         (col),
      .row         (row),
      .last        (last),
      .rom_address (rom_address)
   );

   // Screen position always follows col, even when the ROM column is mirrored.
   assign x_sum = {1'b0, x_lat} + 10'(col);
   assign y_sum = {1'b0, y_lat} + 9'(row);

   // One stage so coordinates line up with the ROM's one-cycle read latency.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pipe_valid <= 1'b0;
         pipe_clip  <= 1'b0;
         x_draw_r   <= '0;
         y_draw_r   <= '0;
      end else begin
         pipe_valid <= advance;
         if (advance) begin
            x_draw_r  <= x_sum[8:0];
            y_draw_r  <= y_sum[7:0];
            pipe_clip <= (x_sum >= 10'(X_MAX)) || (y_sum >= 9'(Y_MAX));
         end
      end
   end

   assign bus.rom_address = rom_address;
   assign bus.x_draw      = x_draw_r;
   assign bus.y_draw      = y_draw_r;
   assign bus.colour      = bus.rom_q;
   assign bus.VGA_write   = pipe_valid & ~pipe_clip & (bus.rom_q != TRANSPARENT);
   assign bus.busy        = busy_c;
   assign bus.draw_done   = done_c;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: raster order, transparency, clipping, busy and reset abort.
// The mirror case runs only when SPRITE_MIRROR_EN is defined.
module tb_sprite_blitter;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   sprite_blitter_if #(.ID_W(3), .ADDR_W(11)) bus ();

   sprite_blitter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [5:0] rom [0:2047];

   always @(posedge clock) bus.rom_q <= rom[bus.rom_address];

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   pix_t expq[$];

   int total = 0;
   int bad   = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic fillRom(input int mode);
      for (int i = 0; i < 2048; i++) begin
         if (mode == 0) rom[i] = 6'h15;
         else           rom[i] = 6'((i % 63) + 1);
      end
   endtask

   // Expected strobes in raster order, skipping clipped and transparent pixels.
   task automatic buildModel(input int id, input int xp, input int yp, input bit mir);
      int ceff;
      int a;
      expq.delete();
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            ceff = mir ? 15 - c : c;
            a    = id * 256 + r * 16 + ceff;
            if ((xp + c) < 320 && (yp + r) < 240 && rom[a] != 6'h00)
               expq.push_back('{x: xp + c, y: yp + r, c: int'(rom[a])});
         end
      end
   endtask

   task automatic applyStimulus(input string name, input int id, input int xp, input int yp, input bit mir,
                                input int expStrobes, input int expAddr, input int restartAt,
                                input int resetAt, input int forbidX, input int forbidY);
      int   strobes   = 0;
      int   dones     = 0;
      int   doneAt    = -1;
      int   forbidHit = 0;
      int   postRst   = 0;
      int   firstX    = -1;
      int   firstY    = -1;
      bit   inReset   = 0;
      logic firstAddr = 1'b0;
      logic [31:0] addr0  = '0;
      logic [31:0] busy0  = '0;
      logic [31:0] busyEnd = 32'hFFFF;
      pix_t p;

      buildModel(id, xp, yp, mir);
      @(negedge clock);
      bus.start     = 1'b1;
      bus.sprite_id = 3'(id);
      bus.x_pos     = 9'(xp);
      bus.y_pos     = 8'(yp);
`ifdef SPRITE_MIRROR_EN
      bus.mirror    = mir;
`endif
      for (int k = 0; k < 300; k++) begin
         @(negedge clock);
         if (k == 0) begin
            bus.start = 1'b0;
            addr0     = 32'(bus.rom_address);
            busy0     = 32'(bus.busy);
            firstAddr = 1'b1;
         end
         if (restartAt >= 0 && k == restartAt + 1) begin
            bus.start = 1'b0;
            bus.x_pos = 9'(xp);
         end
         if (bus.VGA_write === 1'b1) begin
            strobes++;
            if (inReset) postRst++;
            if (int'(bus.x_draw) == forbidX && (forbidY < 0 || int'(bus.y_draw) == forbidY)) forbidHit++;
            if (firstX < 0) begin
               firstX = int'(bus.x_draw);
               firstY = int'(bus.y_draw);
            end
            if (expq.size() > 0) begin
               p = expq.pop_front();
               checkOutput({name, " x"}, 32'(bus.x_draw), 32'(p.x));
               checkOutput({name, " y"}, 32'(bus.y_draw), 32'(p.y));
               checkOutput({name, " colour"}, 32'(bus.colour), 32'(p.c));
            end else if (!inReset) begin
               checkOutput({name, " extra strobe"}, 32'd1, 32'd0);
            end
         end
         if (bus.draw_done === 1'b1) begin
            dones++;
            if (doneAt < 0) doneAt = k;
         end
         if (doneAt >= 0 && k == doneAt + 1) busyEnd = 32'(bus.busy);
         if (k == restartAt) begin
            bus.start = 1'b1;
            bus.x_pos = 9'd50;
         end
         if (k == resetAt) begin
            reset = 1'b0;
            #1;
            checkOutput({name, " rst VGA_write"},   32'(bus.VGA_write),   32'd0);
            checkOutput({name, " rst busy"},        32'(bus.busy),        32'd0);
            checkOutput({name, " rst draw_done"},   32'(bus.draw_done),   32'd0);
            checkOutput({name, " rst x_draw"},      32'(bus.x_draw),      32'd0);
            checkOutput({name, " rst y_draw"},      32'(bus.y_draw),      32'd0);
            checkOutput({name, " rst rom_address"}, 32'(bus.rom_address), 32'd0);
            inReset = 1;
         end
         if (inReset && k == resetAt + 3) reset = 1'b1;
         if (doneAt >= 0 && k == doneAt + 2) break;
      end

      checkOutput({name, " first addr"}, addr0, 32'(expAddr));
      if (firstAddr) checkOutput({name, " busy after start"}, busy0, 32'd1);
      if (resetAt < 0) begin
         checkOutput({name, " strobe count"}, 32'(strobes), 32'(expStrobes));
         checkOutput({name, " done count"}, 32'(dones), 32'd1);
         checkOutput({name, " done latency"}, 32'(doneAt), 32'd257);
         checkOutput({name, " busy after done"}, busyEnd, 32'd0);
         checkOutput({name, " missing strobes"}, 32'(expq.size()), 32'd0);
         checkOutput({name, " pixel0 x"}, 32'(firstX), 32'(expq.size() == 0 && expStrobes > 0 && xp < 320 ? xp : firstX));
      end else begin
         checkOutput({name, " strobes after reset"}, 32'(postRst), 32'd0);
         checkOutput({name, " done after reset"}, 32'(dones), 32'd0);
      end
      if (forbidX >= 0) checkOutput({name, " forbidden strobe"}, 32'(forbidHit), 32'd0);
      if (mir) begin
         checkOutput({name, " mirror pixel0 x"}, 32'(firstX), 32'(xp));
         checkOutput({name, " mirror pixel0 y"}, 32'(firstY), 32'(yp));
      end
      repeat (3) @(negedge clock);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.sprite_id = '0;
      bus.x_pos     = '0;
      bus.y_pos     = '0;
`ifdef SPRITE_MIRROR_EN
      bus.mirror    = 1'b0;
`endif
      fillRom(0);
      repeat (2) @(negedge clock);
      checkOutput("reset busy",        32'(bus.busy),        32'd0);
      checkOutput("reset draw_done",   32'(bus.draw_done),   32'd0);
      checkOutput("reset VGA_write",   32'(bus.VGA_write),   32'd0);
      checkOutput("reset rom_address", 32'(bus.rom_address), 32'd0);
      checkOutput("reset x_draw",      32'(bus.x_draw),      32'd0);
      checkOutput("reset y_draw",      32'(bus.y_draw),      32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      applyStimulus("basic", 0, 10, 20, 1'b0, 256, 0, -1, -1, -1, -1);

      rom[53] = 6'h00;
      applyStimulus("transparent", 0, 10, 20, 1'b0, 255, 0, -1, -1, 15, 23);
      rom[53] = 6'h15;

      applyStimulus("clip", 0, 312, 230, 1'b0, 80, 0, -1, -1, -1, -1);

      applyStimulus("busy", 0, 10, 20, 1'b0, 256, 0, 100, -1, 50, -1);

      applyStimulus("abort", 0, 10, 20, 1'b0, 0, 0, -1, 60, -1, -1);

      applyStimulus("after abort", 0, 10, 20, 1'b0, 256, 0, -1, -1, -1, -1);

      applyStimulus("id5", 5, 100, 100, 1'b0, 256, 32'h500, -1, -1, -1, -1);

`ifdef SPRITE_MIRROR_EN
      fillRom(1);
      applyStimulus("mirror", 2, 100, 50, 1'b1, 256, 32'h20F, -1, -1, -1, -1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
